// File: rtl/spw_light_pkg.sv
// Shared definitions for the spw_light time-code controller: register map,
// bit positions, capture entry layout and scheduler states.
package spw_light_pkg;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned FILL_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_TX_PERIOD = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_TX_TIME   = 3'd4;

    localparam int unsigned STAT_OVF     = 8;
    localparam int unsigned STAT_SEQ_ERR = 9;

    localparam int unsigned CTRL_CAP_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_TX_AUTO = 2;
    localparam int unsigned CTRL_FLUSH   = 3;

    localparam int unsigned TX_ONESHOT   = 31;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [5:0] tc_time;
    } tc_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ISSUE
    } tx_state_e;
endpackage

// File: rtl/spw_light_tc_fifo.sv
// Synchronous capture FIFO for received time-codes; a pop frees room for a
// push in the same cycle, so a full FIFO accepts push+pop together.
module spw_light_tc_fifo
    import spw_light_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  tc_entry_t         wdata,
    output tc_entry_t         head_c,
    output logic [FILL_W-1:0] count,
    output logic              full,
    output logic              empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    tc_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] count_next;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = FILL_W'(count + 1'b1);
        else if (do_pop && !do_push)
            count_next = FILL_W'(count - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            count <= count_next;
            full  <= (count_next == FILL_W'(DEPTH));
            empty <= (count_next == '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
                if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/spw_light_timecode_ctrl.sv
// Avalon-MM controller for the spw_light time-code path: captures received
// time-codes into a FIFO with IRQ, and schedules periodic/one-shot transmits.
module spw_light_timecode_ctrl
    import spw_light_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PERIOD_W   = 24,
    parameter int unsigned PERIOD_RST = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic              link_running,
    input  logic              tick_out,
    input  logic [5:0]        time_out,
    input  logic [1:0]        ctrl_out,
    output logic              tick_in,
    output logic [5:0]        time_in,
    output logic [1:0]        ctrl_in
);
    logic                cap_en, irq_en, tx_auto;
    logic                ovf, seq_err, have_last;
    logic [5:0]          last_time, exp_time;
    logic [PERIOD_W-1:0] tx_period, reload, cnt, cnt_next;
    tc_entry_t           tx_code, wr_code, send_code, fifo_head;
    tx_state_e           state, state_next;
    logic                wr_status, wr_ctrl, wr_period, wr_txtime, rd_fifo;
    logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic                drop, seq_bad, oneshot, issue_next;
    logic [FILL_W-1:0]   fifo_count;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign wr_status = write & (address == ADDR_STATUS);
    assign wr_ctrl   = write & (address == ADDR_CONTROL);
    assign wr_period = write & (address == ADDR_TX_PERIOD);
    assign wr_txtime = write & (address == ADDR_TX_TIME);
    assign rd_fifo   = read  & (address == ADDR_DATA);
    assign wr_code   = writedata[7:0];
    assign oneshot   = wr_txtime & writedata[TX_ONESHOT];
    assign send_code = wr_txtime ? wr_code : tx_code;

    // Sink for write-data bits that no register implements.
    assign unused_wdata = ^writedata;

    assign fifo_push  = tick_out & cap_en;
    assign fifo_pop   = rd_fifo & ~fifo_empty;
    assign fifo_flush = wr_ctrl & writedata[CTRL_FLUSH];
    assign drop       = fifo_push & fifo_full & ~fifo_pop;
    assign exp_time   = 6'(last_time + 6'd1);
    assign seq_bad    = fifo_push & have_last & (time_out != exp_time);
    assign reload     = (tx_period == '0) ? '0 : PERIOD_W'(tx_period - 1'b1);

    spw_light_tc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wdata   ({ctrl_out, time_out}),
        .head_c  (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Register file, sticky flags and sequence tracking; flag set beats W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_en    <= 1'b0;
            irq_en    <= 1'b0;
            tx_auto   <= 1'b0;
            ovf       <= 1'b0;
            seq_err   <= 1'b0;
            have_last <= 1'b0;
            last_time <= '0;
            tx_period <= PERIOD_W'(PERIOD_RST);
            tx_code   <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                cap_en  <= writedata[CTRL_CAP_EN];
                irq_en  <= writedata[CTRL_IRQ_EN];
                tx_auto <= writedata[CTRL_TX_AUTO];
            end
            if (wr_status && writedata[STAT_OVF])     ovf     <= 1'b0;
            if (drop)                                 ovf     <= 1'b1;
            if (wr_status && writedata[STAT_SEQ_ERR]) seq_err <= 1'b0;
            if (seq_bad)                              seq_err <= 1'b1;
            if (fifo_push) begin
                have_last <= 1'b1;
                last_time <= time_out;
            end
            if (fifo_flush || (wr_ctrl && writedata[CTRL_CAP_EN] && !cap_en))
                have_last <= 1'b0;
            if (wr_period) tx_period <= writedata[PERIOD_W-1:0];
            if (wr_txtime)
                tx_code <= wr_code;
            else if (state == ST_ISSUE)
                tx_code.tc_time <= 6'(tx_code.tc_time + 6'd1);
            irq <= irq_en & (~fifo_empty | ovf | seq_err);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:      if (!fifo_empty) rd_mux = {23'b0, 1'b1, fifo_head};
            ADDR_STATUS:    rd_mux = {22'b0, seq_err, ovf, 1'b0, fifo_full, fifo_empty, fifo_count};
            ADDR_CONTROL:   rd_mux = {29'b0, tx_auto, irq_en, cap_en};
            ADDR_TX_PERIOD: rd_mux = 32'(tx_period);
            ADDR_TX_TIME:   rd_mux = {24'b0, tx_code};
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else if (read) readdata <= rd_mux;
    end

    // Scheduler: COUNT spends TX_PERIOD-1 cycles, ISSUE the last one of the period.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (oneshot) begin
                    state_next = ST_ISSUE;
                end else if (tx_auto) begin
                    state_next = ST_COUNT;
                    cnt_next   = reload;
                end
            end
            ST_COUNT: begin
                if (!tx_auto) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt <= PERIOD_W'(1)) begin
                    state_next = ST_ISSUE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = PERIOD_W'(cnt - 1'b1);
                end
            end
            ST_ISSUE: begin
                state_next = tx_auto ? ST_COUNT : ST_IDLE;
                cnt_next   = tx_auto ? reload : '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (!link_running) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    assign issue_next = (state_next == ST_ISSUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tick_in <= 1'b0;
            time_in <= '0;
            ctrl_in <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            tick_in <= issue_next;
            if (issue_next) begin
                time_in <= send_code.tc_time;
                ctrl_in <= send_code.ctrl;
            end
        end
    end
endmodule

// File: tb/tb_spw_light_timecode_ctrl.sv
// Self-checking bench for spw_light_timecode_ctrl: directed scenarios plus a
// randomized capture run checked against a queue-based model.
module tb_spw_light_timecode_ctrl;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned PERIOD_RST = 50000;
    localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_CONTROL = 3'd2,
                           A_PERIOD = 3'd3, A_TXTIME = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic        link_running = 1'b0;
    logic        tick_out = 1'b0;
    logic [5:0]  time_out = '0;
    logic [1:0]  ctrl_out = '0;
    logic        tick_in;
    logic [5:0]  time_in;
    logic [1:0]  ctrl_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the capture side.
    logic [7:0] mq[$];
    bit         m_ovf, m_seq, m_have, m_cap;
    int         m_last;

    spw_light_timecode_ctrl #(.FIFO_DEPTH(DEPTH), .PERIOD_W(24), .PERIOD_RST(PERIOD_RST)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq), .link_running(link_running),
        .tick_out(tick_out), .time_out(time_out), .ctrl_out(ctrl_out),
        .tick_in(tick_in), .time_in(time_in), .ctrl_in(ctrl_in)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        mq.delete(); m_ovf = 0; m_seq = 0; m_have = 0; m_cap = 0; m_last = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; read = 0; write = 0; tick_out = 0; link_running = 0;
        address = '0; writedata = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
        d = readdata;
    endtask

    // Capture rule: sequence check always, entry kept only if room exists.
    task automatic model_capture(input logic [7:0] e);
        if (!m_cap) return;
        if (m_have && int'(e[5:0]) != (m_last + 1) % 64) m_seq = 1;
        m_have = 1; m_last = int'(e[5:0]);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
    endtask

    function automatic logic [31:0] model_pop();
        if (mq.size() == 0) return 32'h0;
        return {23'b0, 1'b1, mq.pop_front()};
    endfunction

    function automatic logic [31:0] model_status();
        int n = mq.size();
        return {22'b0, m_seq, m_ovf, 1'b0, (n == DEPTH), (n == 0), 5'(n)};
    endfunction

    task automatic send_tc(input logic [5:0] t, input logic [1:0] c);
        tick_out = 1'b1; time_out = t; ctrl_out = c;
        step();
        tick_out = 1'b0;
        model_capture({c, t});
    endtask

    task automatic pop_push(input logic [5:0] t, input logic [1:0] c, output logic [31:0] d);
        address = A_DATA; read = 1'b1; tick_out = 1'b1; time_out = t; ctrl_out = c;
        step();
        read = 1'b0; tick_out = 1'b0;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        n_tests++; if ({irq, tick_in, time_in, ctrl_in} !== 10'h0) begin n_fail++;
            $display("FAIL reset_outputs: got %h exp 0", {irq, tick_in, time_in, ctrl_in}); end
        n_tests++; if (readdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_readdata: got %h exp 0", readdata); end
        bus_read(A_STATUS, rd);
        n_tests++; if (rd !== model_status()) begin n_fail++;
            $display("FAIL reset_status: got %h exp %h", rd, model_status()); end
        bus_read(A_PERIOD, rd);
        n_tests++; if (rd !== 32'(PERIOD_RST)) begin n_fail++;
            $display("FAIL reset_period: got %0d exp %0d", rd, PERIOD_RST); end
        bus_read(A_DATA, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++;
            $display("FAIL empty_data_read: got %h exp 0", rd); end
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++;
            $display("FAIL unmapped_read: got %h exp 0", rd); end
        bus_read(A_CONTROL, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++;
            $display("FAIL unmapped_write_ignored: got %h exp 0", rd); end
    endtask

    task automatic test_capture_irq();
        logic [31:0] rd, ex;
        do_reset();
        bus_write(A_CONTROL, 32'h3); m_cap = 1;
        for (int i = 5; i <= 7; i++) send_tc(6'(i), 2'd0);
        bus_read(A_STATUS, rd);
        n_tests++; if (rd !== model_status()) begin n_fail++;
            $display("FAIL cap_status: got %h exp %h", rd, model_status()); end
        n_tests++; if (irq !== 1'b1) begin n_fail++;
            $display("FAIL cap_irq_set: got %b exp 1", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, rd);
            ex = model_pop();
            n_tests++; if (rd !== ex) begin n_fail++;
                $display("FAIL cap_data_read%0d: got %h exp %h", i, rd, ex); end
        end
        step();
        n_tests++; if (irq !== 1'b0) begin n_fail++;
            $display("FAIL cap_irq_clear: got %b exp 0", irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, ex;
        do_reset();
        bus_write(A_CONTROL, 32'h1); m_cap = 1;
        for (int i = 1; i <= 5; i++) send_tc(6'(i), 2'd2);
        bus_read(A_STATUS, rd);
        n_tests++; if (rd !== model_status() || rd !== 32'h144) begin n_fail++;
            $display("FAIL ovf_status: got %h exp %h", rd, model_status()); end
        for (int k = 0; k < 2; k++) begin
            pop_push(6'(6 + k), 2'd1, rd);
            ex = model_pop(); model_capture({2'd1, 6'(6 + k)});
            n_tests++; if (rd !== ex) begin n_fail++;
                $display("FAIL ovf_poppush_data%0d: got %h exp %h", k, rd, ex); end
            bus_read(A_STATUS, rd);
            n_tests++; if (rd !== model_status()) begin n_fail++;
                $display("FAIL ovf_poppush_status%0d: got %h exp %h", k, rd, model_status()); end
            if (k == 0) begin
                bus_write(A_STATUS, 32'h100); m_ovf = 0;
                bus_read(A_STATUS, rd);
                n_tests++; if (rd !== model_status()) begin n_fail++;
                    $display("FAIL ovf_w1c: got %h exp %h", rd, model_status()); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, rd);
            ex = model_pop();
            n_tests++; if (rd !== ex) begin n_fail++;
                $display("FAIL ovf_drain%0d: got %h exp %h", i, rd, ex); end
        end
    endtask

    task automatic test_seq();
        logic [31:0] rd;
        int times[4] = '{62, 63, 0, 2};
        do_reset();
        bus_write(A_CONTROL, 32'h1); m_cap = 1;
        for (int i = 0; i < 4; i++) begin
            send_tc(6'(times[i]), 2'd0);
            bus_read(A_STATUS, rd);
            n_tests++; if (rd !== model_status()) begin n_fail++;
                $display("FAIL seq_t%0d: got %h exp %h", times[i], rd, model_status()); end
        end
        bus_write(A_STATUS, 32'h200); m_seq = 0;
        bus_write(A_CONTROL, 32'h9); mq.delete(); m_have = 0;
        bus_read(A_CONTROL, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++;
            $display("FAIL flush_reads_zero: got %h exp 1", rd); end
        send_tc(6'd40, 2'd0);
        bus_read(A_STATUS, rd);
        n_tests++; if (rd !== model_status()) begin n_fail++;
            $display("FAIL seq_after_flush: got %h exp %h", rd, model_status()); end
    endtask

    task automatic test_tx_periodic();
        logic [31:0] rd;
        int cyc[$]; logic [5:0] tv[$];
        int exp_t, extra;
        do_reset();
        link_running = 1'b1;
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_TXTIME, 32'd62);
        bus_write(A_CONTROL, 32'h4);
        for (int c = 0; c < 100 && cyc.size() < 4; c++) begin
            step();
            if (tick_in) begin cyc.push_back(c); tv.push_back(time_in); end
        end
        n_tests++; if (cyc.size() !== 4) begin n_fail++;
            $display("FAIL tx_tick_count: got %0d exp 4", cyc.size()); end
        exp_t = 62;
        for (int i = 0; i < cyc.size(); i++) begin
            n_tests++; if (tv[i] !== 6'(exp_t)) begin n_fail++;
                $display("FAIL tx_time%0d: got %0d exp %0d", i, tv[i], exp_t); end
            if (i > 0) begin
                n_tests++; if (cyc[i] - cyc[i-1] !== 10) begin n_fail++;
                    $display("FAIL tx_interval%0d: got %0d exp 10", i, cyc[i] - cyc[i-1]); end
            end
            exp_t = (exp_t + 1) % 64;
        end
        repeat (4) step();
        link_running = 1'b0;
        extra = 0;
        for (int c = 0; c < 40; c++) begin step(); if (tick_in) extra++; end
        n_tests++; if (extra !== 0) begin n_fail++;
            $display("FAIL tx_link_drop: got %0d ticks exp 0", extra); end
        bus_read(A_TXTIME, rd);
        n_tests++; if (rd !== 32'(exp_t)) begin n_fail++;
            $display("FAIL tx_time_after: got %h exp %h", rd, exp_t); end
        bus_write(A_CONTROL, 32'h0);
        link_running = 1'b1;
        bus_write(A_TXTIME, 32'h8000_0033);
        n_tests++; if (tick_in !== 1'b1 || time_in !== 6'h33) begin n_fail++;
            $display("FAIL tx_idle_after_drop: got tick %b time %h exp 1 33", tick_in, time_in); end
        step();
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        int n, first; logic [5:0] t; logic [1:0] c2;
        do_reset();
        link_running = 1'b1;
        bus_write(A_TXTIME, 32'h8000_0015);
        n = 0; first = -1; t = '0; c2 = '0;
        for (int c = 0; c < 20; c++) begin
            if (tick_in) begin n++; if (first < 0) first = c; t = time_in; c2 = ctrl_in; end
            step();
        end
        n_tests++; if (n !== 1 || first !== 0) begin n_fail++;
            $display("FAIL oneshot_count: got %0d at %0d exp 1 at 0", n, first); end
        n_tests++; if ({c2, t} !== 8'h15) begin n_fail++;
            $display("FAIL oneshot_value: got %h exp 15", {c2, t}); end
        bus_read(A_TXTIME, rd);
        n_tests++; if (rd !== 32'h16) begin n_fail++;
            $display("FAIL oneshot_incr: got %h exp 16", rd); end
        link_running = 1'b0;
        bus_write(A_TXTIME, 32'h8000_0095);
        n = 0;
        for (int c = 0; c < 20; c++) begin if (tick_in) n++; step(); end
        n_tests++; if (n !== 0) begin n_fail++;
            $display("FAIL oneshot_link_down: got %0d ticks exp 0", n); end
        bus_read(A_TXTIME, rd);
        n_tests++; if (rd !== 32'h95) begin n_fail++;
            $display("FAIL oneshot_no_incr: got %h exp 95", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int n;
        do_reset();
        link_running = 1'b1;
        bus_write(A_CONTROL, 32'h3); m_cap = 1;
        bus_write(A_TXTIME, 32'h8000_00EA);
        step(); step();
        send_tc(6'd9, 2'd0); send_tc(6'd10, 2'd0);
        bus_write(A_PERIOD, 32'd100);
        bus_write(A_CONTROL, 32'h7);
        repeat (5) step();
        bus_read(A_STATUS, rd);
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if ({irq, tick_in, time_in, ctrl_in} !== 10'h0) begin n_fail++;
            $display("FAIL midreset_outputs: got %h exp 0", {irq, tick_in, time_in, ctrl_in}); end
        n_tests++; if (readdata !== 32'h0) begin n_fail++;
            $display("FAIL midreset_readdata: got %h exp 0", readdata); end
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();
        bus_read(A_STATUS, rd);
        n_tests++; if (rd !== model_status()) begin n_fail++;
            $display("FAIL midreset_status: got %h exp %h", rd, model_status()); end
        bus_read(A_PERIOD, rd);
        n_tests++; if (rd !== 32'(PERIOD_RST)) begin n_fail++;
            $display("FAIL midreset_period: got %0d exp %0d", rd, PERIOD_RST); end
        bus_read(A_CONTROL, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++;
            $display("FAIL midreset_control: got %h exp 0", rd); end
        n = 0;
        for (int c = 0; c < 120; c++) begin step(); if (tick_in) n++; end
        n_tests++; if (n !== 0) begin n_fail++;
            $display("FAIL midreset_no_tick: got %0d exp 0", n); end
    endtask

    task automatic test_random_capture();
        logic [31:0] rd, ex;
        logic [5:0] t;
        logic [1:0] c;
        bit do_tick, do_read;
        int prev;
        do_reset();
        bus_write(A_CONTROL, 32'h3); m_cap = 1;
        prev = int'($urandom_range(0, 63));
        for (int i = 0; i < 300; i++) begin
            do_tick = ($urandom_range(0, 1) == 1);
            do_read = ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 9) < 8) ? 6'((prev + 1) % 64) : 6'($urandom_range(0, 63));
            c = 2'($urandom_range(0, 3));
            address = A_DATA; read = do_read; tick_out = do_tick; time_out = t; ctrl_out = c;
            step();
            read = 1'b0; tick_out = 1'b0;
            if (do_read) begin
                ex = model_pop();
                n_tests++; if (readdata !== ex) begin n_fail++;
                    $display("FAIL rand_read_cycle%0d: got %h exp %h", i, readdata, ex); end
            end
            if (do_tick) begin model_capture({c, t}); prev = int'(t); end
        end
        bus_read(A_STATUS, rd);
        n_tests++; if (rd !== model_status()) begin n_fail++;
            $display("FAIL rand_status: got %h exp %h", rd, model_status()); end
        step();
        n_tests++; if (irq !== (mq.size() != 0 || m_ovf || m_seq)) begin n_fail++;
            $display("FAIL rand_irq: got %b exp %b", irq, (mq.size() != 0 || m_ovf || m_seq)); end
    endtask

    initial begin
        test_reset();
        test_capture_irq();
        test_overflow();
        test_seq();
        test_tx_periodic();
        test_oneshot();
        test_reset_mid();
        test_random_capture();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
